mem_load_unit: RTL and testbench

//  MEM-stage load engine directly downstream of the MEM pipeline latch. Takes latched
//  rd_memory / funct3 / address_target, runs a req/ack read on the data-memory port,

---
 rtl/mem_load_unit_pkg.sv | 39 +++
 rtl/mem_load_unit_if.sv | 10 +
 rtl/mem_load_unit_load_extend.sv | 33 +++
 rtl/mem_load_unit.sv | 132 +++++++++++++
 tb/tb_mem_load_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_load_unit_pkg.sv
// Shared load-unit definitions: funct3 load codes, FSM states, fault causes and
// the legality/alignment helpers used by the accept decision.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_ILLEGAL  = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Byte loads can never be misaligned; halves need bit 0 clear, words both bits.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LH, F3_LHU: return lo[0];
            F3_LW:         return lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Data-memory read port: registered req/addr from the load unit, rdata qualified by ack.
interface mem_load_unit_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (output dmem_req, output dmem_addr, input dmem_rdata, input dmem_ack);
  modport slave  (input dmem_req, input dmem_addr, output dmem_rdata, output dmem_ack);
endinterface

// File: rtl/mem_load_unit_load_extend.sv
// Combinational little-endian lane select plus sign/zero extension of a returned word.
// Lane comes from the captured low address bits; half lanes use offset[1] only.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {24'h0, byte_lane};
      F3_LH:   result = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  result = {16'h0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load engine: accepts a latched load, runs one req/ack read, returns the
// extended result or a fault pulse, and stalls upstream while a read is in flight.
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   stg_clk,
  input  logic                   reset,
  input  logic                   rd_memory,
  input  logic [2:0]             funct3_,
  input  logic [31:0]            address_target,
  mem_load_unit_if.master        dmem,
  output logic                   stall,
  output logic                   load_valid,
  output logic [31:0]            load_data,
  output logic                   load_fault,
  output logic [1:0]             fault_cause
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;
  cause_t      cause_q, cause_d;
  logic [31:0] ext_data;

  load_extend u_extend (
    .rdata  (dmem.dmem_rdata),
    .funct3 (f3_q),
    .offset (off_q),
    .result (ext_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    fault_d = 1'b0;
    cause_d = cause_q;
    stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_memory) begin
          // Illegal encoding takes priority over the alignment check.
          if (!f3_legal(funct3_)) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
            data_d  = '0;
          end else if (f3_misaligned(funct3_, address_target[1:0])) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
            data_d  = '0;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            addr_d  = {address_target[31:2], 2'b00};
            f3_d    = funct3_;
            off_d   = address_target[1:0];
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.dmem_ack) begin
          valid_d = 1'b1;
          data_d  = ext_data;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          data_d  = '0;
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge stg_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  assign dmem.dmem_req  = req_q;
  assign dmem.dmem_addr = addr_q;
  assign load_valid     = valid_q;
  assign load_data      = data_q;
  assign load_fault     = fault_q;
  assign fault_cause    = cause_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit with a 4-cycle timeout so the timeout path is short.
module tb_mem_load_unit;
  import mem_pkg::*;

  logic        stg_clk;
  logic        reset;
  logic        rd_memory;
  logic [2:0]  funct3_;
  logic [31:0] address_target;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_fault;
  logic [1:0]  fault_cause;

  int tests_run = 0;
  int tests_failed = 0;

  mem_load_unit_if dmem_bus ();

  mem_load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .stg_clk        (stg_clk),
    .reset          (reset),
    .rd_memory      (rd_memory),
    .funct3_        (funct3_),
    .address_target (address_target),
    .dmem           (dmem_bus.master),
    .stall          (stall),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_fault     (load_fault),
    .fault_cause    (fault_cause)
  );

  initial begin
    stg_clk = 1'b0;
    forever #5 stg_clk = ~stg_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge stg_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rd_memory = 1'b0;
    funct3_ = 3'b000;
    address_target = '0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    #2;
    tests_run++;
    if (dmem_bus.dmem_req !== 1'b0 || dmem_bus.dmem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_dmem: req=%b addr=%h, want 0/0", dmem_bus.dmem_req, dmem_bus.dmem_addr);
    end
    tests_run++;
    if (load_valid !== 1'b0 || load_fault !== 1'b0 || load_data !== 32'h0 || fault_cause !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b fault=%b data=%h cause=%b, want all 0",
               load_valid, load_fault, load_data, fault_cause);
    end
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b want 0", stall);
    end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    logic stall_ok;
    logic no_early_valid;
    rd_memory = 1'b1;
    funct3_ = F3_LW;
    address_target = 32'h100;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL lw_accept_stall: got %b want 1", stall);
    end
    tick();
    rd_memory = 1'b0;
    address_target = 32'h0;
    tests_run++;
    if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL lw_issue: req=%b addr=%h, want 1/00000100", dmem_bus.dmem_req, dmem_bus.dmem_addr);
    end
    stall_ok = 1'b1;
    no_early_valid = 1'b1;
    repeat (2) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
      if (load_valid !== 1'b0 || dmem_bus.dmem_req !== 1'b1) no_early_valid = 1'b0;
    end
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    tests_run++;
    if (stall_ok !== 1'b1 || no_early_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL lw_wait: stall_held=%b quiet=%b, want 1/1", stall_ok, no_early_valid);
    end
    tick();
    dmem_bus.dmem_ack = 1'b0;
    tests_run++;
    if (load_valid !== 1'b1 || load_data !== 32'hDEADBEEF || dmem_bus.dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_result: valid=%b data=%h req=%b, want 1/deadbeef/0",
               load_valid, load_data, dmem_bus.dmem_req);
    end
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL lw_stall_release: got %b want 0", stall);
    end
    tick();
    tests_run++;
    if (load_valid !== 1'b0 || load_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL lw_pulse_hold: valid=%b data=%h, want 0/deadbeef", load_valid, load_data);
    end
  endtask

  task automatic test_fault();
    logic [2:0]  f3_tab [4] = '{3'b010, 3'b011, 3'b111, 3'b001};
    logic [31:0] ad_tab [4] = '{32'h102, 32'h100, 32'h101, 32'h101};
    logic [1:0]  ca_tab [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      rd_memory = 1'b1;
      funct3_ = f3_tab[i];
      address_target = ad_tab[i];
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault_stall[%0d]: got %b want 0", i, stall);
      end
      tick();
      rd_memory = 1'b0;
      tests_run++;
      if (load_fault !== 1'b1 || fault_cause !== ca_tab[i] || dmem_bus.dmem_req !== 1'b0 || load_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault_pulse[%0d]: fault=%b cause=%b req=%b valid=%b, want 1/%b/0/0",
                 i, load_fault, fault_cause, dmem_bus.dmem_req, load_valid, ca_tab[i]);
      end
      tick();
      tests_run++;
      if (load_fault !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault_clear[%0d]: fault=%b req=%b, want 0/0", i, load_fault, dmem_bus.dmem_req);
      end
    end
  endtask

  task automatic test_extend();
    logic [2:0]  f3_tab [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad_tab [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h104};
    logic [31:0] ex_tab [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
    logic [31:0] wa_tab [5] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 5; i++) begin
      rd_memory = 1'b1;
      funct3_ = f3_tab[i];
      address_target = ad_tab[i];
      tick();
      rd_memory = 1'b0;
      tests_run++;
      if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== wa_tab[i]) begin
        tests_failed++;
        $display("FAIL ext_issue[%0d]: req=%b addr=%h, want 1/%h", i, dmem_bus.dmem_req, dmem_bus.dmem_addr, wa_tab[i]);
      end
      dmem_bus.dmem_ack = 1'b1;
      dmem_bus.dmem_rdata = 32'h80FF7F01;
      tick();
      dmem_bus.dmem_ack = 1'b0;
      tests_run++;
      if (load_valid !== 1'b1 || load_data !== ex_tab[i]) begin
        tests_failed++;
        $display("FAIL ext_data[%0d]: valid=%b data=%h, want 1/%h", i, load_valid, load_data, ex_tab[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic early;
    rd_memory = 1'b1;
    funct3_ = F3_LW;
    address_target = 32'h300;
    tick();
    rd_memory = 1'b0;
    early = 1'b0;
    repeat (3) begin
      tick();
      if (load_fault !== 1'b0 || dmem_bus.dmem_req !== 1'b1 || stall !== 1'b1) early = 1'b1;
    end
    tests_run++;
    if (early !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: premature abort seen=%b want 0", early);
    end
    tick();
    tests_run++;
    if (load_fault !== 1'b1 || fault_cause !== 2'b11 || load_data !== 32'h0 || dmem_bus.dmem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fault: fault=%b cause=%b data=%h req=%b, want 1/11/00000000/0",
               load_fault, fault_cause, load_data, dmem_bus.dmem_req);
    end
    tick();
    // Ack arriving on the last counted edge must beat the timeout.
    rd_memory = 1'b1;
    address_target = 32'h304;
    tick();
    rd_memory = 1'b0;
    repeat (3) tick();
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h12345678;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    tests_run++;
    if (load_valid !== 1'b1 || load_fault !== 1'b0 || load_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL timeout_ack_wins: valid=%b fault=%b data=%h, want 1/0/12345678",
               load_valid, load_fault, load_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_memory = 1'b1;
    funct3_ = F3_LW;
    address_target = 32'h200;
    tick();
    address_target = 32'h204;
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h11111111;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    tests_run++;
    if (load_valid !== 1'b1 || load_data !== 32'h11111111 || dmem_bus.dmem_req !== 1'b0 || stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: valid=%b data=%h req=%b stall=%b, want 1/11111111/0/1",
               load_valid, load_data, dmem_bus.dmem_req, stall);
    end
    tick();
    rd_memory = 1'b0;
    tests_run++;
    if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 32'h204 || load_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_reissue: req=%b addr=%h valid=%b, want 1/00000204/0",
               dmem_bus.dmem_req, dmem_bus.dmem_addr, load_valid);
    end
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'h22222222;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    tests_run++;
    if (load_valid !== 1'b1 || load_data !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL b2b_second: valid=%b data=%h, want 1/22222222", load_valid, load_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    rd_memory = 1'b1;
    funct3_ = F3_LW;
    address_target = 32'h400;
    tick();
    rd_memory = 1'b0;
    tests_run++;
    if (dmem_bus.dmem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait_issue: req=%b want 1", dmem_bus.dmem_req);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (dmem_bus.dmem_req !== 1'b0 || load_fault !== 1'b0 || load_valid !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_async: req=%b fault=%b valid=%b stall=%b, want 0/0/0/0",
               dmem_bus.dmem_req, load_fault, load_valid, stall);
    end
    #2 reset = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_bus.dmem_ack = 1'b0;
    tests_run++;
    if (load_valid !== 1'b0 || load_fault !== 1'b0 || dmem_bus.dmem_req !== 1'b0 || load_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_wait_stray_ack: valid=%b fault=%b req=%b data=%h, want 0/0/0/00000000",
               load_valid, load_fault, dmem_bus.dmem_req, load_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_fault();
    test_extend();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
